branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Two-stage pipelined flag and branch-resolution unit sitting directly downstream of the ALU/zero-detect logic in the ARM datapath.
- Stage 1 registers per-slice 16-bit zero-detect results of the ALU result and the CBZ/CBNZ operand.
- Stage 2 combines them, updates the NZCV flag register for flag-setting ops, and resolves B.cond/CBZ/CBNZ into a taken/not-taken decision.
- Valid/ready handshake on both sides; synchronous flush from the control unit.

Parameters:
- WIDTH, 64, datapath width in bits; must be a multiple of SLICE.
- SLICE, 16, zero-detect slice width; NS = WIDTH/SLICE slices.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  synchronous active-low reset
- in_valid  input  1  upstream presents an instruction
- in_ready  output  1  stage 1 can accept this cycle
- result  input  WIDTH  ALU result
- alu_c  input  1  ALU carry out
- alu_v  input  1  ALU overflow
- set_flags  input  1  instruction writes NZCV (ADDS/SUBS/ANDS)
- is_bcond  input  1  B.cond instruction
- is_cbz  input  1  CBZ instruction
- is_cbnz  input  1  CBNZ instruction
- cond  input  4  ARM condition code for B.cond
- rt_val  input  WIDTH  register operand tested by CBZ/CBNZ
- flush  input  1  squash all in-flight instructions
- out_valid  output  1  stage 2 holds a resolved instruction
- out_ready  input  1  downstream accepts this cycle
- take_branch  output  1  resolved decision, meaningful when out_valid
- flags  output  4  committed {N,Z,C,V}

Behaviour:
- Reset (reset_n=0 at clock edge): s1_valid=0, s2_valid=0, flags=4'b0000, take_branch=0. in_ready reads 1 on the first cycle after reset deasserts. Reset overrides flush and every handshake.
- Stage 1 captures on in_valid && in_ready:
  - res_zs[NS], where bit i = NOR of result[i*SLICE +: SLICE];
  - rt_zs[NS];
  - N = result[WIDTH-1], alu_c, alu_v, set_flags, op type bits, cond.
- Advance: s2_free = !s2_valid || out_ready; in_ready = !s1_valid || s2_free. Stage 1 moves to stage 2 when s1_valid && s2_free. Both stages hold contents unchanged while stalled.
- Stage 2 combinational:
  - Z_new = AND of res_zs.
  - rt_zero = AND of rt_zs.
  - take_branch:
    - CBZ: rt_zero.
    - CBNZ: !rt_zero.
    - B.cond: evaluated against the committed flags register.
    - Other ops: 0.
- Condition codes:
  - 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 1.
- Flag commit: on the out_valid && out_ready edge, if the stage-2 instruction has set_flags, flags <= {N, Z_new, C, V}. Otherwise flags hold.
- Flag ordering: an instruction commits flags on the same edge it leaves stage 2, before any younger instruction enters stage 2. B.cond therefore always sees the flags of the youngest older flag-setter, so no forwarding path is needed.
- Flush (flush=1, reset_n=1): s1_valid and s2_valid <= 0 at the edge. An instruction in stage 2 with out_ready=1 in the flush cycle is dropped and its flags are not committed. An in_valid capture in the same cycle is discarded. Flags and take_branch are otherwise unchanged.
- Mutual exclusion:
  - Multiple op-type bits set together: priority CBZ > CBNZ > B.cond.
  - set_flags is independent of branch type.
- Latency: 2 cycles from accept to out_valid when unstalled; throughput 1 per cycle.
- Full: both stages valid and out_ready=0, so in_ready=0. Empty: out_valid=0, and take_branch holds its last registered value.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with in_valid=1 -> out_valid=0, flags=0000, in_ready=1 after release.
- SUBS, result=0, alu_c=1, alu_v=0, set_flags=1 -> out_valid at +2 cycles. After acceptance flags=0110. The next B.cond with cond=0 (EQ) gives take_branch=1; cond=1 (NE) gives 0.
- CBZ with rt_val=0x0001_0000_0000_0000 (upper-slice-only bit) -> take_branch=0. rt_val=0 -> 1. CBNZ with the same two values -> 1 then 0.
- Signed compare: SUBS with result=0x8000_0000_0000_0000, alu_v=0 -> flags N=1. Then B.cond LT gives 1, GE gives 0, GT gives 0, LE gives 1.
- Backpressure: 3 back-to-back instructions with out_ready=0 -> in_ready drops after 2 accepts and stage contents hold. Raise out_ready -> outputs drain in order with no loss or duplication.
- Flush: stage 2 holds ADDS (result=5) with out_ready=1 and stage 1 valid, assert flush -> both valids 0 next cycle and flags unchanged from the prior value.

Source files
------------

// File: rtl/branch_resolve_if.sv
// Handshake and operand bundle between the ALU/zero-detect front end,
// the branch resolution unit and its downstream consumer.
interface branch_resolve_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] result;
    logic             alu_c;
    logic             alu_v;
    logic             set_flags;
    logic             is_bcond;
    logic             is_cbz;
    logic             is_cbnz;
    logic [3:0]       cond;
    logic [WIDTH-1:0] rt_val;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic             take_branch;
    logic [3:0]       flags;

    modport master (
        output in_valid, result, alu_c, alu_v, set_flags, is_bcond, is_cbz,
               is_cbnz, cond, rt_val, flush, out_ready,
        input  in_ready, out_valid, take_branch, flags
    );

    modport slave (
        input  in_valid, result, alu_c, alu_v, set_flags, is_bcond, is_cbz,
               is_cbnz, cond, rt_val, flush, out_ready,
        output in_ready, out_valid, take_branch, flags
    );
endinterface

// File: rtl/branch_resolve.sv
// Two-stage flag and branch-resolution unit: per-slice zero detect in stage 1,
// NZCV commit and B.cond/CBZ/CBNZ resolution in stage 2.
module branch_resolve #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input logic             clk,
    input logic             reset_n,
    branch_resolve_if.slave bus
);
    localparam int NS = WIDTH / SLICE;

    logic [NS-1:0] res_zs;
    logic [NS-1:0] rt_zs;

    logic          s1_valid;
    logic [NS-1:0] s1_res_zs;
    logic [NS-1:0] s1_rt_zs;
    logic          s1_n;
    logic          s1_c;
    logic          s1_v;
    logic          s1_sf;
    logic          s1_bcond;
    logic          s1_cbz;
    logic          s1_cbnz;
    logic [3:0]    s1_cond;

    logic          s2_valid;
    logic [NS-1:0] s2_res_zs;
    logic [NS-1:0] s2_rt_zs;
    logic          s2_n;
    logic          s2_c;
    logic          s2_v;
    logic          s2_sf;
    logic          s2_bcond;
    logic          s2_cbz;
    logic          s2_cbnz;
    logic [3:0]    s2_cond;

    logic          s2_free;
    logic          s2_fire;
    logic          s1_fire;
    logic          in_fire;
    logic [3:0]    flags_q;
    logic          z_new;
    logic          rt_zero;
    logic          cond_true;
    logic          take_comb;
    logic          take_hold;

    always_comb begin
        res_zs = '0;
        rt_zs  = '0;
        for (int i = 0; i < NS; i++) begin
            res_zs[i] = ~|bus.result[i*SLICE +: SLICE];
            rt_zs[i]  = ~|bus.rt_val[i*SLICE +: SLICE];
        end
    end

    assign s2_free      = !s2_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_free;
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign s1_fire      = s1_valid && s2_free;
    assign s2_fire      = s2_valid && bus.out_ready;

    // Flags commit as the setter leaves stage 2, so a younger B.cond entering
    // stage 2 on that same edge already sees them without forwarding.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            flags_q   <= 4'b0000;
            take_hold <= 1'b0;
        end else begin
            if (s2_valid)
                take_hold <= take_comb;
            if (bus.flush) begin
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
            end else begin
                if (s2_fire && s2_sf)
                    flags_q <= {s2_n, z_new, s2_c, s2_v};
                if (s2_free)
                    s2_valid <= s1_valid;
                if (bus.in_ready)
                    s1_valid <= bus.in_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_res_zs <= res_zs;
            s1_rt_zs  <= rt_zs;
            s1_n      <= bus.result[WIDTH-1];
            s1_c      <= bus.alu_c;
            s1_v      <= bus.alu_v;
            s1_sf     <= bus.set_flags;
            s1_bcond  <= bus.is_bcond;
            s1_cbz    <= bus.is_cbz;
            s1_cbnz   <= bus.is_cbnz;
            s1_cond   <= bus.cond;
        end
        if (s1_fire) begin
            s2_res_zs <= s1_res_zs;
            s2_rt_zs  <= s1_rt_zs;
            s2_n      <= s1_n;
            s2_c      <= s1_c;
            s2_v      <= s1_v;
            s2_sf     <= s1_sf;
            s2_bcond  <= s1_bcond;
            s2_cbz    <= s1_cbz;
            s2_cbnz   <= s1_cbnz;
            s2_cond   <= s1_cond;
        end
    end

    assign z_new   = &s2_res_zs;
    assign rt_zero = &s2_rt_zs;

    // B.cond is judged against the committed flags, never the stage-2 ones.
    always_comb begin
        cond_true = 1'b0;
        case (s2_cond)
            4'd0:  cond_true = flags_q[2];
            4'd1:  cond_true = !flags_q[2];
            4'd2:  cond_true = flags_q[1];
            4'd3:  cond_true = !flags_q[1];
            4'd4:  cond_true = flags_q[3];
            4'd5:  cond_true = !flags_q[3];
            4'd6:  cond_true = flags_q[0];
            4'd7:  cond_true = !flags_q[0];
            4'd8:  cond_true = flags_q[1] && !flags_q[2];
            4'd9:  cond_true = !flags_q[1] || flags_q[2];
            4'd10: cond_true = flags_q[3] == flags_q[0];
            4'd11: cond_true = flags_q[3] != flags_q[0];
            4'd12: cond_true = !flags_q[2] && (flags_q[3] == flags_q[0]);
            4'd13: cond_true = flags_q[2] || (flags_q[3] != flags_q[0]);
            default: cond_true = 1'b1;
        endcase
    end

    always_comb begin
        take_comb = 1'b0;
        if (s2_cbz)
            take_comb = rt_zero;
        else if (s2_cbnz)
            take_comb = !rt_zero;
        else if (s2_bcond)
            take_comb = cond_true;
    end

    assign bus.out_valid   = s2_valid;
    assign bus.take_branch = s2_valid ? take_comb : take_hold;
    assign bus.flags       = flags_q;
endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: expected decisions are queued at accept
// time and compared as each instruction leaves stage 2.
module tb_branch_resolve;
    typedef struct {
        logic       take;
        logic       sf;
        logic [3:0] newFlags;
        int         acceptCycle;
    } scoreItem_t;

    logic clk;
    logic reset_n;
    int   cycle = 0;
    int   checks = 0;
    int   errors = 0;
    int   lastLatency = 0;

    logic [3:0] progFlags;
    logic [3:0] commitFlags = 4'b0000;
    scoreItem_t scoreboard[$];
    scoreItem_t popped;

    branch_resolve_if #(.WIDTH(64)) bus ();

    branch_resolve #(.WIDTH(64), .SLICE(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic condEval(input logic [3:0] f, input logic [3:0] c);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy & !z;
            4'd9:  return !cy | z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z & (n == v);
            4'd13: return z | (n != v);
            default: return 1'b1;
        endcase
    endfunction

    // Called at a falling edge; returns at the next falling edge after acceptance.
    task automatic applyStimulus(input logic [63:0] res, input logic c, input logic v,
                                 input logic sf, input logic bc, input logic cz,
                                 input logic cnz, input logic [3:0] cnd,
                                 input logic [63:0] rt);
        scoreItem_t it;
        int waited = 0;
        bus.in_valid  = 1'b1;
        bus.result    = res;
        bus.alu_c     = c;
        bus.alu_v     = v;
        bus.set_flags = sf;
        bus.is_bcond  = bc;
        bus.is_cbz    = cz;
        bus.is_cbnz   = cnz;
        bus.cond      = cnd;
        bus.rt_val    = rt;
        #4;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            #4;
            waited++;
        end
        if (waited >= 50) begin
            checkOutput("accept_timeout", bus.in_ready, 1);
        end else begin
            if (cz)
                it.take = (rt == 64'd0);
            else if (cnz)
                it.take = (rt != 64'd0);
            else if (bc)
                it.take = condEval(progFlags, cnd);
            else
                it.take = 1'b0;
            it.sf          = sf;
            it.newFlags    = {res[63], res == 64'd0, c, v};
            it.acceptCycle = cycle;
            if (sf)
                progFlags = it.newFlags;
            scoreboard.push_back(it);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic subs(input logic [63:0] res, input logic c, input logic v);
        applyStimulus(res, c, v, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 64'd0);
    endtask

    task automatic bcond(input logic [3:0] cnd);
        applyStimulus(64'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, cnd, 64'd0);
    endtask

    task automatic cbz(input logic [63:0] rt);
        applyStimulus(64'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, rt);
    endtask

    task automatic cbnz(input logic [63:0] rt);
        applyStimulus(64'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, rt);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (scoreboard.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50)
            checkOutput("drain_timeout", scoreboard.size(), 0);
    endtask

    // Compares every instruction leaving stage 2 against the head of the queue.
    always begin
        @(negedge clk);
        #4;
        if (reset_n && !bus.flush && bus.out_valid && bus.out_ready) begin
            checkOutput("output_expected", scoreboard.size() > 0, 1);
            if (scoreboard.size() > 0) begin
                popped = scoreboard.pop_front();
                checkOutput("take_branch", bus.take_branch, popped.take);
                checkOutput("flags_in_s2", bus.flags, commitFlags);
                lastLatency = cycle - popped.acceptCycle;
                if (popped.sf)
                    commitFlags = popped.newFlags;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0] r;
        int sel;
        reset_n       = 1'b0;
        progFlags     = 4'b0000;
        bus.in_valid  = 1'b1;
        bus.result    = 64'd0;
        bus.alu_c     = 1'b0;
        bus.alu_v     = 1'b0;
        bus.set_flags = 1'b1;
        bus.is_bcond  = 1'b0;
        bus.is_cbz    = 1'b0;
        bus.is_cbnz   = 1'b0;
        bus.cond      = 4'd0;
        bus.rt_val    = 64'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        reset_n      = 1'b1;
        #1;
        checkOutput("reset_out_valid", bus.out_valid, 0);
        checkOutput("reset_flags", bus.flags, 4'b0000);
        checkOutput("reset_in_ready", bus.in_ready, 1);
        checkOutput("reset_take", bus.take_branch, 0);
        @(negedge clk);

        $display("[TB] SUBS zero then EQ/NE");
        subs(64'd0, 1'b1, 1'b0);
        waitDrain();
        checkOutput("subs_latency", lastLatency, 2);
        checkOutput("flags_after_subs", bus.flags, 4'b0110);
        bcond(4'd0);
        bcond(4'd1);
        waitDrain();

        $display("[TB] CBZ/CBNZ upper slice");
        cbz(64'h0001_0000_0000_0000);
        cbz(64'd0);
        cbnz(64'h0001_0000_0000_0000);
        cbnz(64'd0);
        waitDrain();

        $display("[TB] signed compare");
        subs(64'h8000_0000_0000_0000, 1'b0, 1'b0);
        bcond(4'd11);
        bcond(4'd10);
        bcond(4'd12);
        bcond(4'd13);
        waitDrain();
        checkOutput("flags_negative", bus.flags, 4'b1000);

        $display("[TB] op priority");
        applyStimulus(64'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd14, 64'd0);
        applyStimulus(64'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd14, 64'd0);
        waitDrain();
        checkOutput("flags_with_cbz", bus.flags, 4'b0111);

        $display("[TB] condition sweep");
        for (int k = 0; k < 4; k++) begin
            sel = $urandom_range(0, 2);
            if (sel == 0)
                r = 64'd0;
            else if (sel == 1)
                r = {1'b1, 31'($urandom), 32'($urandom)};
            else
                r = {1'b0, 31'($urandom), 31'($urandom), 1'b1};
            subs(r, 1'($urandom), 1'($urandom));
            for (int c = 0; c < 16; c++)
                bcond(4'(c));
        end
        waitDrain();

        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        cbz(64'd0);
        cbnz(64'd0);
        bus.in_valid = 1'b1;
        bus.is_cbz   = 1'b0;
        bus.is_cbnz  = 1'b1;
        bus.rt_val   = 64'd5;
        #4;
        checkOutput("full_in_ready", bus.in_ready, 0);
        checkOutput("full_out_valid", bus.out_valid, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #4;
            checkOutput("stall_in_ready", bus.in_ready, 0);
            checkOutput("stall_take_hold", bus.take_branch, 1);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        cbnz(64'd5);
        waitDrain();

        $display("[TB] flush");
        subs(64'd0, 1'b0, 1'b0);
        waitDrain();
        applyStimulus(64'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 64'd0);
        bcond(4'd0);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.is_cbz   = 1'b1;
        #4;
        checkOutput("flush_pre_out_valid", bus.out_valid, 1);
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.is_cbz   = 1'b0;
        #1;
        scoreboard.delete();
        progFlags = commitFlags;
        checkOutput("flush_out_valid", bus.out_valid, 0);
        checkOutput("flush_in_ready", bus.in_ready, 1);
        checkOutput("flush_flags_kept", bus.flags, 4'b0100);
        repeat (4) @(negedge clk);
        checkOutput("flush_no_output", bus.out_valid, 0);
        bcond(4'd0);
        waitDrain();

        checkOutput("final_queue_empty", scoreboard.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
